// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validated at mid-bit, data sampled once per bit period,
// byte held in rx_data until acknowledged; a low stop bit parks the FSM in BREAK.
//   state | meaning
//   IDLE  | line idle, waiting for falling edge of rx_s
//   START | timing to middle of start bit for validation
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | timing to middle of stop bit
//   BREAK | framing error seen, waiting for line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [13:0] BIT_TC  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_TC = 14'(HALF_BIT - 1);

    state_t      state;
    logic [13:0] cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        rx_m;
    logic        rx_s;
    logic        done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
        end
    end

    assign done = (state == STOP) && (cnt == BIT_TC) && rx_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_TC) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data <= shreg;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase

            // a completing byte beats a simultaneous acknowledge
            if (done) begin
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack)
                    overrun <= 1'b1;
                else if (rx_ack)
                    overrun <= 1'b0;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx with a byte-level reference model.
module tb_uart_rx;

    localparam int C   = 16;
    localparam int H   = 8;
    // Rx fall -> rx_valid rise: 2 sync flops + IDLE->START edge + half bit + 9 bit periods
    localparam int LAT = 3 + H + 9 * C;

    logic       CLK;
    logic       RST;
    logic       Rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Rx       (Rx),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    logic valid_prev = 1'b0;

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_ferr;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (frame_err)
            ferr_cnt <= ferr_cnt + 1;
        if (rx_valid && !valid_prev)
            rise_cyc <= cyc;
        valid_prev <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"},  rx_data,  exp_data);
        check({tag, "_valid"}, rx_valid, exp_valid);
        check({tag, "_ovr"},   overrun,  exp_ovr);
        check({tag, "_ferr"},  ferr_cnt, exp_ferr);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge CLK);
        #1 Rx = 1'b0;
        t_start = cyc;
        repeat (C) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            #1 Rx = b[i];
            repeat (C) @(posedge CLK);
        end
        #1 Rx = stop;
        repeat (C) @(posedge CLK);
        #1;
    endtask

    // optionally raise rx_ack for exactly the cycle in which the stop bit is judged
    task automatic send_ack(input logic [7:0] b, input logic stop, input logic ack_at_end);
        fork
            send_frame(b, stop);
            if (ack_at_end) begin
                @(posedge CLK);
                repeat (LAT - 1) @(posedge CLK);
                #1 rx_ack = 1'b1;
                @(posedge CLK);
                #1 rx_ack = 1'b0;
            end
        join
        if (stop) begin
            exp_ovr   = (exp_valid && !ack_at_end) ? 1'b1 : (ack_at_end ? 1'b0 : exp_ovr);
            exp_valid = 1'b1;
            exp_data  = b;
        end else begin
            exp_ferr++;
            if (ack_at_end) begin
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
            end
        end
    endtask

    task automatic do_ack();
        @(posedge CLK);
        #1 rx_ack = 1'b1;
        @(posedge CLK);
        #1 rx_ack = 1'b0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       st;
        logic       ak;

        RST = 1'b0;
        Rx = 1'b1;
        rx_ack = 1'b0;
        exp_data = 8'h00;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset");
        check("reset_busy", busy, 1'b0);
        RST = 1'b1;
        repeat (4) @(posedge CLK);

        // basic frame with latency check
        send_ack(8'hA5, 1'b1, 1'b0);
        check_all("a5");
        check("a5_latency", rise_cyc - t_start, LAT);
        check("a5_busy", busy, 1'b0);
        do_ack();
        check("a5_ack_valid", rx_valid, 1'b0);

        // short glitch must be rejected at the start-bit check
        @(posedge CLK);
        #1 Rx = 1'b0;
        repeat (4) @(posedge CLK);
        #1 Rx = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check("glitch_busy_hi", busy, 1'b1);
        repeat (14) @(posedge CLK);
        #1 check("glitch_busy_lo", busy, 1'b0);
        check_all("glitch");

        // bad stop bit then held-low line
        send_ack(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge CLK);
        #1 check("break_busy", busy, 1'b1);
        check_all("break");
        Rx = 1'b1;
        repeat (6) @(posedge CLK);
        #1 check("break_exit_busy", busy, 1'b0);

        // overrun
        send_ack(8'h11, 1'b1, 1'b0);
        send_ack(8'h22, 1'b1, 1'b0);
        check_all("ovr");
        do_ack();
        check_all("ovr_ack");

        // ack coinciding with completion
        send_ack(8'h55, 1'b1, 1'b0);
        send_ack(8'h66, 1'b1, 1'b1);
        check_all("coinc");
        do_ack();

        // reset in the middle of a frame
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (60) @(posedge CLK);
                #1 RST = 1'b0;
                repeat (3) @(posedge CLK);
                #1 RST = 1'b1;
            end
        join
        exp_data = 8'h00;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        repeat (4) @(posedge CLK);
        #1 check_all("midrst");
        check("midrst_busy", busy, 1'b0);
        send_ack(8'h81, 1'b1, 1'b0);
        check_all("after_rst");

        // randomized frames, stop bits and acknowledge timing
        for (int n = 0; n < 14; n++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            ak = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                do_ack();
            send_ack(b, st, ak);
            check("rnd_busy", busy, !st);
            check_all("rnd");
            Rx = 1'b1;
            repeat ($urandom_range(4, 20)) @(posedge CLK);
            #1 check("rnd_idle", busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416: clock cycles per bit (9600 baud at 100 MHz); legal range 4 to 16383.
REQ-002 Parameter HALF_BIT, default CLKS_PER_BIT/2: cycles from start-bit detection to the start-bit validation sample.
REQ-003 CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Rx  input  1  serial line, asynchronous to CLK; idle high; frame = start(0), 8 data bits LSB first, stop(1).
REQ-006 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-007 rx_data  output  8  last correctly framed byte received.
REQ-008 rx_valid  output  1  level; rx_data holds an unconsumed byte.
REQ-009 overrun  output  1  sticky; a byte was overwritten before acknowledge.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s only.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and BREAK; a 14-bit cycle counter and a 4-bit bit counter.
REQ-014 IDLE: rx_s==0 -> START, counter cleared to 0; otherwise stay.
REQ-015 START: when counter==HALF_BIT-1, rx_s==0 -> DATA with counter and bit counter cleared; rx_s==1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: when counter==CLKS_PER_BIT-1, the shift register SHALL shift right with rx_s into bit 7, the bit counter SHALL increment and the counter SHALL clear; after the 8th sample -> STOP.
REQ-017 STOP: when counter==CLKS_PER_BIT-1, rx_s==1 -> load rx_data from the shift register, set rx_valid on the next edge, -> IDLE.
REQ-018 STOP: when counter==CLKS_PER_BIT-1, rx_s==0 -> pulse frame_err for 1 cycle, discard the byte, leave rx_valid and rx_data unchanged, -> BREAK.
REQ-019 BREAK: stay until rx_s==1, then -> IDLE; a held-low line SHALL NOT generate repeated frames.
REQ-020 rx_ack while rx_valid==1 SHALL clear rx_valid on the next edge; rx_ack while rx_valid==0 SHALL be ignored.
REQ-021 A byte completing while rx_valid==1 and rx_ack==0 SHALL overwrite rx_data, keep rx_valid=1 and set overrun.
REQ-022 A byte completing in the same cycle as rx_ack SHALL win: rx_valid stays 1, rx_data takes the new byte, overrun is not set.
REQ-023 overrun SHALL clear only on reset or on a cycle with rx_ack==1 and no simultaneous overrun event.
REQ-024 The stop-bit sample SHALL occur HALF_BIT+9*CLKS_PER_BIT cycles after START entry; rx_valid SHALL rise exactly 1 cycle after that sample.
REQ-025 Counters SHALL never wrap: every counter clear is explicit at the compare points above.

Reset
REQ-026 While RST==0: state=IDLE; counters=0; synchronizer flops=1; rx_data=8'h00; rx_valid=0; overrun=0; frame_err=0; busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err; after release, reception resumes on the next falling edge of rx_s.
REQ-028 Release of RST SHALL be sampled synchronously; the first FSM transition occurs no earlier than the 1st rising edge after release.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-029 Send 0xA5 with a correct frame -> rx_data=0xA5, rx_valid=1 exactly 1 cycle after the stop sample, frame_err=0, overrun=0; rx_ack -> rx_valid=0 on the next cycle.
REQ-030 Drive a 4-cycle low glitch on an idle line -> FSM returns to IDLE from START; rx_valid, frame_err and rx_data are unchanged.
REQ-031 Send 0x3C with stop bit=0, then hold Rx low for 40 cycles -> one frame_err pulse, rx_valid stays 0, busy stays high in BREAK until Rx returns high.
REQ-032 Send 0x11 then 0x22 with no rx_ack -> rx_data=0x22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0 and overrun=0.
REQ-033 Send 0x55 and assert rx_ack in the exact cycle 0x66 completes -> rx_data=0x66, rx_valid=1, overrun=0.
REQ-034 Assert RST low in the middle of DATA for 0xFF, release, then send 0x81 -> only 0x81 is reported; no frame_err pulse occurs.
